// File: rtl/rotate_result_stage.sv
// rtl/rotate_result_stage.sv - captures rotator results with Z/N/C/V flags into a 2-entry FIFO
// Optional: ROTATE_PARITY_FLAG_EN adds out_p, the stored even-parity flag of the head entry.
module rotate_result_stage #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] res_in,
    input  logic [4:0]        shamt_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_z,
    output logic              out_n,
    output logic              out_c,
    output logic              out_v,
`ifdef ROTATE_PARITY_FLAG_EN
    output logic              out_p,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        count,
    output logic              sticky_v,
    input  logic              sticky_clr
);

`ifdef ROTATE_PARITY_FLAG_EN
    localparam int FLAG_W = 5;
`else
    localparam int FLAG_W = 4;
`endif
    localparam int ENTRY_W = DATA_W + FLAG_W;
    localparam logic [1:0] FULL = DEPTH[1:0];

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] head_nx;
    logic [ENTRY_W-1:0] new_entry;
    logic               wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
    logic [1:0]         count_nx;
    logic               push, pop;
    logic               z_new, n_new, c_new, v_new;

    // C is the last bit rotated out, which lands in bit 7 for amounts 1..8
    always_comb begin
        z_new = (res_in == '0);
        n_new = res_in[DATA_W-1];
        c_new = (shamt_in >= 5'd1 && shamt_in <= 5'd8) ? res_in[DATA_W-1] : 1'b0;
        v_new = (shamt_in > 5'd8);
`ifdef ROTATE_PARITY_FLAG_EN
        new_entry = {~^res_in, v_new, c_new, n_new, z_new, res_in};
`else
        new_entry = {v_new, c_new, n_new, z_new, res_in};
`endif
    end

    always_comb begin
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        wr_ptr_nx = push ? ~wr_ptr : wr_ptr;
        rd_ptr_nx = pop ? ~rd_ptr : rd_ptr;
        count_nx  = count;
        if (push && !pop)
            count_nx = count + 2'd1;
        else if (pop && !push)
            count_nx = count - 2'd1;
        // the slot being written this cycle may become head immediately
        head_nx = (push && (wr_ptr == rd_ptr_nx)) ? new_entry : mem[rd_ptr_nx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sticky_v  <= 1'b0;
            head      <= '0;
            mem[0]    <= '0;
            mem[1]    <= '0;
        end else begin
            if (push)
                mem[wr_ptr] <= new_entry;
            wr_ptr    <= wr_ptr_nx;
            rd_ptr    <= rd_ptr_nx;
            count     <= count_nx;
            in_ready  <= (count_nx != FULL);
            out_valid <= (count_nx != 2'd0);
            // outputs keep their last values once the FIFO drains
            if (count_nx != 2'd0)
                head <= head_nx;
            if (push && v_new)
                sticky_v <= 1'b1;
            else if (sticky_clr)
                sticky_v <= 1'b0;
        end
    end

    assign out_data = head[DATA_W-1:0];
    assign out_z    = head[DATA_W];
    assign out_n    = head[DATA_W+1];
    assign out_c    = head[DATA_W+2];
    assign out_v    = head[DATA_W+3];
`ifdef ROTATE_PARITY_FLAG_EN
    assign out_p    = head[DATA_W+4];
`endif

endmodule

// File: tb/tb_rotate_result_stage.sv
// tb/tb_rotate_result_stage.sv - directed self-checking bench for rotate_result_stage
module tb_rotate_result_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] res_in;
    logic [4:0] shamt_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_z, out_n, out_c, out_v;
`ifdef ROTATE_PARITY_FLAG_EN
    logic       out_p;
`endif
    logic       out_valid;
    logic       out_ready;
    logic [1:0] count;
    logic       sticky_v;
    logic       sticky_clr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rotate_result_stage dut (
        .clk(clk), .rst(rst), .res_in(res_in), .shamt_in(shamt_in),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_z(out_z), .out_n(out_n), .out_c(out_c), .out_v(out_v),
`ifdef ROTATE_PARITY_FLAG_EN
        .out_p(out_p),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .count(count),
        .sticky_v(sticky_v), .sticky_clr(sticky_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // z n c v packed as a nibble for compact checks
    task automatic chk_head(input string tag, input logic [7:0] d, input logic [3:0] znvc);
        chk({tag, ".data"}, {24'd0, out_data}, {24'd0, d});
        chk({tag, ".zncv"}, {28'd0, out_z, out_n, out_c, out_v}, {28'd0, znvc});
    endtask

    initial begin
        rst = 1'b1; res_in = 8'h00; shamt_in = 5'd0; in_valid = 1'b0;
        out_ready = 1'b0; sticky_clr = 1'b0;
        step();
        rst = 1'b0;
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.ready", 32'(in_ready), 32'd1);
        chk("rst.sticky", 32'(sticky_v), 32'd0);
        chk_head("rst", 8'h00, 4'b0000);

        // 0xC0 rotated by 1: N and C set
        in_valid = 1'b1; res_in = 8'hC0; shamt_in = 5'd1;
        step();
        chk("c0.valid", 32'(out_valid), 32'd1);
        chk("c0.count", 32'(count), 32'd1);
        chk_head("c0", 8'hC0, 4'b0110);

        // simultaneous pop of 0xC0 and push of 0x00 at count=1
        out_ready = 1'b1; res_in = 8'h00; shamt_in = 5'd0;
        step();
        chk("zero.count", 32'(count), 32'd1);
        chk_head("zero", 8'h00, 4'b1000);
`ifdef ROTATE_PARITY_FLAG_EN
        chk("zero.p", 32'(out_p), 32'd1);
`endif

        // out-of-range amount: V set, sticky set
        res_in = 8'h00; shamt_in = 5'd9;
        step();
        chk("v9.count", 32'(count), 32'd1);
        chk_head("v9", 8'h00, 4'b1001);
        chk("v9.sticky", 32'(sticky_v), 32'd1);

        // drain: outputs hold last values
        in_valid = 1'b0;
        step();
        chk("drain.count", 32'(count), 32'd0);
        chk("drain.valid", 32'(out_valid), 32'd0);
        chk_head("drain.hold", 8'h00, 4'b1001);
        chk("drain.sticky", 32'(sticky_v), 32'd1);

        // non-V push keeps sticky
        out_ready = 1'b0; in_valid = 1'b1; res_in = 8'h81; shamt_in = 5'd3;
        step();
        chk("s81.sticky", 32'(sticky_v), 32'd1);
        chk_head("s81", 8'h81, 4'b0110);
`ifdef ROTATE_PARITY_FLAG_EN
        chk("s81.p", 32'(out_p), 32'd1);
`endif
        in_valid = 1'b0; sticky_clr = 1'b1;
        step();
        chk("clr.sticky", 32'(sticky_v), 32'd0);
        in_valid = 1'b1; res_in = 8'h00; shamt_in = 5'd20;
        step();
        sticky_clr = 1'b0; in_valid = 1'b0;
        chk("clrset.sticky", 32'(sticky_v), 32'd1);
        chk("clrset.count", 32'(count), 32'd2);
        chk("clrset.ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        chk("pop81.count", 32'(count), 32'd1);
        chk("pop81.ready", 32'(in_ready), 32'd1);
        chk_head("pop81", 8'h00, 4'b1001);
        step();
        chk("pop2.count", 32'(count), 32'd0);

        // backpressure: third push held off
        out_ready = 1'b0; in_valid = 1'b1; res_in = 8'h11; shamt_in = 5'd2;
        step();
        chk("bp11.count", 32'(count), 32'd1);
        res_in = 8'h22;
        step();
        chk("bp22.count", 32'(count), 32'd2);
        chk("bp22.ready", 32'(in_ready), 32'd0);
        res_in = 8'h33;
        step();
        chk("bp33.count", 32'(count), 32'd2);
        chk_head("bp33.head", 8'h11, 4'b0000);
        out_ready = 1'b1;
        step();
        chk("bp.pop1.count", 32'(count), 32'd1);
        chk("bp.pop1.ready", 32'(in_ready), 32'd1);
        chk("bp.pop1.data", 32'(out_data), 32'h22);
        step();
        chk("bp.pop2.count", 32'(count), 32'd1);
        chk("bp.pop2.data", 32'(out_data), 32'h33);
        in_valid = 1'b0;
        step();
        chk("bp.pop3.count", 32'(count), 32'd0);
        chk("bp.pop3.valid", 32'(out_valid), 32'd0);

        // reset while full with a presented entry
        out_ready = 1'b0; in_valid = 1'b1; res_in = 8'hAA; shamt_in = 5'd4;
        step();
        res_in = 8'hBB;
        step();
        chk("full.count", 32'(count), 32'd2);
        rst = 1'b1; res_in = 8'hCC;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("rstf.count", 32'(count), 32'd0);
        chk("rstf.valid", 32'(out_valid), 32'd0);
        chk("rstf.ready", 32'(in_ready), 32'd1);
        chk("rstf.data", 32'(out_data), 32'h00);
        step();
        chk("rstf.after.count", 32'(count), 32'd0);
        chk("rstf.after.valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rotate_result_stage.md
Name: rotate_result_stage

Overview:
Downstream stage of the ALU rotate-right datapath. Captures the rotator's 8-bit result, together with the shift amount that produced it, under a valid/ready handshake. Derives Z/N/C/V flags and buffers up to two results in a FIFO for the writeback/flag-register consumer. Absorbs consumer backpressure so the combinational rotator never needs to hold its operands.

Parameters:
DEPTH, 2, FIFO entries; fixed at 2, pointer width 1 bit, count width 2 bits.
DATA_W, 8, result width; must stay 8, since flag rules assume bit 7 is the MSB.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
res_in  input  8  rotator output
shamt_in  input  5  shift amount presented to the rotator for res_in
in_valid  input  1  res_in/shamt_in valid
in_ready  output  1  stage can accept an entry
out_data  output  8  head-of-FIFO result
out_z  output  1  zero flag of head entry
out_n  output  1  negative flag of head entry
out_c  output  1  carry flag of head entry
out_v  output  1  range-violation flag of head entry
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head entry
count  output  2  current occupancy, 0..2
sticky_v  output  1  sticky OR of every accepted V flag
sticky_clr  input  1  clears sticky_v

Behaviour:
- Reset (rst=1 at a clock edge) sets: count=0, pointers=0, out_valid=0, in_ready=1, sticky_v=0, and out_data/out_z/out_n/out_c/out_v=0. Reset mid-transfer discards all entries; an in_valid asserted in the same cycle is not accepted.
- Push occurs when in_valid & in_ready. Pop occurs when out_valid & out_ready.
- in_ready = (count != 2). It is a registered comparison and does not depend on out_ready, so there is no combinational path from out_ready to in_ready. When full, a same-cycle pop does not enable a push; in_ready rises the cycle after the pop.
- Flags are computed at push time from the inputs and stored with the data:
  - Z = (res_in == 0).
  - N = res_in[7].
  - C = res_in[7] when 1 <= shamt_in <= 8, else 0. This is the last bit rotated out.
  - V = (shamt_in > 8). The rotator returns 0 for these amounts, so the result is invalid.
- The entry appears on the out_* outputs the cycle after the push; minimum latency is 1 cycle. out_data and flags are driven from the head entry and hold stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop with count=1: count stays 1. The new entry becomes head the cycle after the pop.
- Pop when empty and push when full are both ignored; pointers never move. Pointers wrap 1 -> 0.
- When out_valid=0, the out_* outputs hold their last values; the consumer must ignore them.
- sticky_v is set on a push with V=1 and cleared by sticky_clr. If both happen in the same cycle, the set wins and sticky_v=1.
- count updates as +1 on push only, -1 on pop only, and is unchanged otherwise.

Optional Feature:
Macro ROTATE_PARITY_FLAG_EN.
- When defined: adds output out_p (1 bit), the even-parity flag of the head entry, equal to ~^res_in captured at push and stored per entry. Reset value is 0.
- When undefined: the port and its storage are absent; all other behaviour is identical.

Test Plan:
- rst, then push res_in=0xC0, shamt_in=1 -> next cycle out_valid=1, out_data=0xC0, Z=0, N=1, C=1, V=0, count=1.
- Push res_in=0x00, shamt_in=0 -> Z=1, N=0, C=0, V=0; with ROTATE_PARITY_FLAG_EN defined, out_p=1.
- Push res_in=0x00, shamt_in=9 -> V=1, C=0, sticky_v=1. sticky_v stays 1 through further pushes until sticky_clr pulses; sticky_clr together with a V=1 push leaves sticky_v=1.
- out_ready=0, push 0x11, 0x22, 0x33 back-to-back -> 0x33 is held off (in_ready=0 after two pushes, count=2). Raise out_ready -> pops return 0x11, then 0x22, then 0x33 in order, with no loss or duplication.
- count=1 with simultaneous push 0x44 and pop -> count stays 1 and the next head is 0x44.
- count=2, assert rst with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1; the presented entry is not stored.
